s_axil_register: RTL and testbench
==================================

# s_axil_register

AXI4-Lite slave holding a bank of NUM_REG 32-bit read/write registers, one outstanding write and one outstanding read. It is the responder end of the register-test path: the master BFM writes 1..16 into addresses 0x00..0x3C and reads them back through this block. It is synthesizable and sits directly on an AXI-Lite interconnect port.

## Interface
- S_AXI_DATA_WIDTH, 32: data width; only 32 is supported.
- S_AXI_ADDR_WIDTH, 32: address width.
- NUM_REG, 16: register count, power of two, 2..256.

- ACLK  in  1  clock; all logic on rising edge.
- ARESET  in  1  reset; one clock, synchronous, active-low.
- AWADDR  in  S_AXI_ADDR_WIDTH  write address.
- AWVALID / AWREADY  in / out  1  AW handshake.
- WDATA  in  S_AXI_DATA_WIDTH  write data.
- WSTRB  in  S_AXI_DATA_WIDTH/8  byte enables.
- WVALID / WREADY  in / out  1  W handshake.
- BRESP  out  2  write response.
- BVALID / BREADY  out / in  1  B handshake.
- ARADDR  in  S_AXI_ADDR_WIDTH  read address.
- ARVALID / ARREADY  in / out  1  AR handshake.
- RDATA  out  S_AXI_DATA_WIDTH  read data.
- RRESP  out  2  read response.
- RVALID / RREADY  out / in  1  R handshake.

## Operation
- Register index = addr[2+log2(NUM_REG)-1 : 2]; addr[1:0] ignored.
- Write FSM states: IDLE, HAVE_AW, HAVE_W, RESP.
  - IDLE: AW only -> HAVE_AW (latch address); W only -> HAVE_W (latch data/strobe); both same cycle -> commit, RESP.
  - HAVE_AW + W handshake, or HAVE_W + AW handshake -> commit, RESP.
  - RESP: BVALID=1; on BREADY -> IDLE.
- Commit: each byte lane with WSTRB[k]=1 updated; WSTRB=0 commits nothing but still responds OKAY.
- Read FSM states: IDLE, RESP. AR handshake -> latch RDATA from current contents, RESP; RVALID held until RREADY -> IDLE.
- Read and write in the same cycle to the same index: read returns the pre-write value.
- Responses OKAY (2'b00) unless the Configuration feature says otherwise.

## Timing
- Reset: AWREADY, WREADY, ARREADY, BVALID, RVALID = 0; BRESP, RRESP, RDATA = 0; all registers = 0; both FSMs IDLE.
- Cycle after reset release: AWREADY=WREADY=ARREADY=1.
- AWREADY high only in IDLE/HAVE_W; WREADY only in IDLE/HAVE_AW; ARREADY only in read IDLE. All readies registered.
- Write: final AW/W handshake at cycle N -> register updated and BVALID=1 at N+1. Minimum 2 cycles per write with BREADY held high.
- Read: AR handshake at N -> RVALID=1, RDATA valid at N+1. Minimum 2 cycles per read.
- BVALID/RVALID, BRESP/RRESP/RDATA stable until accepted; never dropped without handshake.
- No combinational path from any input to any output.
- ARESET low mid-transaction: abandons pending transaction next edge; no partial commit; outputs return to reset values.

## Configuration
- S_AXIL_REGISTER_SLVERR_EN defined: any address with bits above index range nonzero (addr >= NUM_REG*4) is out of range; write is discarded with BRESP=2'b10; read returns RDATA=0, RRESP=2'b10.
- Undefined: upper address bits ignored, access aliases modulo NUM_REG, always OKAY.

## Structure
- Package s_axil_register_pkg: RESP_OKAY, RESP_SLVERR, write/read FSM state enums, index-width function/constant.
- Sub-module s_axil_register_file: NUM_REG x 32 storage, one byte-strobed write port, one asynchronous read port, synchronous reset to zero. Top holds the two FSMs and address/data latches.

## Test plan
- Write i+1 to address 4*i for i=0..15 (AW and W simultaneous), read all back -> RDATA = 1..16, all responses OKAY.
- W two cycles before AW, then AW two cycles before W, to 0x08 with 0xA5A5A5A5 -> single BVALID per write, readback 0xA5A5A5A5 matching the last write.
- Write 0xFFFFFFFF to 0x10, then 0x00000000 with WSTRB=4'b0101 -> readback 0xFF00FF00.
- BREADY/RREADY held low 5 cycles -> BVALID/RVALID and payload stable, AWREADY/WREADY/ARREADY stay 0 until accepted.
- Address 0x40: with macro, write gets BRESP=2'b10, read RDATA=0 RRESP=2'b10, register 0 unchanged; without, writes/reads register 0 with OKAY.
- ARESET low while in HAVE_AW -> next cycle all valids 0, registers 0; subsequent write completes normally.

Source files
------------

// File: rtl/s_axil_register_pkg.sv
// Shared constants, FSM state encodings and index-width helper for the AXI4-Lite register slave.
package s_axil_register_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam int unsigned DEFAULT_NUM_REG = 16;

    typedef enum logic [1:0] {
        WR_IDLE    = 2'd0,
        WR_HAVE_AW = 2'd1,
        WR_HAVE_W  = 2'd2,
        WR_RESP    = 2'd3
    } wr_state_e;

    typedef enum logic {
        RD_IDLE = 1'b0,
        RD_RESP = 1'b1
    } rd_state_e;

    function automatic int unsigned idx_width(input int unsigned num_reg);
        return (num_reg > 1) ? $clog2(num_reg) : 1;
    endfunction

endpackage

// File: rtl/s_axil_register_if.sv
// AXI4-Lite bus bundle between an interconnect/master port and the register slave.
interface s_axil_register_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   AWADDR;
    logic                    AWVALID;
    logic                    AWREADY;
    logic [DATA_WIDTH-1:0]   WDATA;
    logic [DATA_WIDTH/8-1:0] WSTRB;
    logic                    WVALID;
    logic                    WREADY;
    logic [1:0]              BRESP;
    logic                    BVALID;
    logic                    BREADY;
    logic [ADDR_WIDTH-1:0]   ARADDR;
    logic                    ARVALID;
    logic                    ARREADY;
    logic [DATA_WIDTH-1:0]   RDATA;
    logic [1:0]              RRESP;
    logic                    RVALID;
    logic                    RREADY;

    modport master (
        output AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
        input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
    );

    modport slave (
        input  AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
        output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
    );
endinterface

// File: rtl/s_axil_register_file.sv
// NUM_REG x DATA_WIDTH register storage: one byte-strobed write port, one asynchronous read port.
module s_axil_register_file
    import s_axil_register_pkg::*;
#(
    parameter  int unsigned NUM_REG    = DEFAULT_NUM_REG,
    parameter  int unsigned DATA_WIDTH = 32,
    localparam int unsigned IW         = idx_width(NUM_REG)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    we,
    input  logic [IW-1:0]           waddr,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic [IW-1:0]           raddr,
    output logic [DATA_WIDTH-1:0]   rdata
);

    logic [NUM_REG-1:0][DATA_WIDTH-1:0] mem_q, mem_d;

    always_comb begin
        mem_d = mem_q;
        if (we) begin
            for (int k = 0; k < DATA_WIDTH / 8; k++) begin
                if (wstrb[k]) mem_d[waddr][8*k +: 8] = wdata[8*k +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) mem_q <= '0;
        else        mem_q <= mem_d;
    end

    // Reads see pre-write contents, so a same-cycle read/write returns the old value.
    assign rdata = mem_q[raddr];

endmodule

// File: rtl/s_axil_register.sv
// AXI4-Lite register-bank slave, one outstanding write and one outstanding read.
// Define S_AXIL_REGISTER_SLVERR_EN to answer out-of-range addresses with SLVERR instead of aliasing.
module s_axil_register
    import s_axil_register_pkg::*;
#(
    parameter int unsigned S_AXI_DATA_WIDTH = 32,
    parameter int unsigned S_AXI_ADDR_WIDTH = 32,
    parameter int unsigned NUM_REG          = DEFAULT_NUM_REG
) (
    input  logic              ACLK,
    input  logic              ARESET,
    s_axil_register_if.slave  s_axi
);

    localparam int unsigned IW = idx_width(NUM_REG);
    localparam int unsigned DW = S_AXI_DATA_WIDTH;
    localparam int unsigned SW = S_AXI_DATA_WIDTH / 8;

    wr_state_e         wr_state_q, wr_state_d;
    rd_state_e         rd_state_q, rd_state_d;
    logic [IW-1:0]     aw_idx_q, aw_idx_d;
    logic              aw_oor_q, aw_oor_d;
    logic [DW-1:0]     wdata_q, wdata_d;
    logic [SW-1:0]     wstrb_q, wstrb_d;
    logic              awready_q, awready_d;
    logic              wready_q, wready_d;
    logic              bvalid_q, bvalid_d;
    logic [1:0]        bresp_q, bresp_d;
    logic              arready_q, arready_d;
    logic              rvalid_q, rvalid_d;
    logic [DW-1:0]     rdata_q, rdata_d;
    logic [1:0]        rresp_q, rresp_d;

    logic              aw_hs, w_hs, ar_hs;
    logic              aw_oor_in, ar_oor_in;
    logic              commit;
    logic [IW-1:0]     cm_idx;
    logic              cm_oor;
    logic [DW-1:0]     cm_data;
    logic [SW-1:0]     cm_strb;
    logic              rf_we;
    logic [DW-1:0]     rf_rdata;
    logic              unused_addr;

    assign aw_hs = s_axi.AWVALID && awready_q;
    assign w_hs  = s_axi.WVALID  && wready_q;
    assign ar_hs = s_axi.ARVALID && arready_q;

`ifdef S_AXIL_REGISTER_SLVERR_EN
    assign aw_oor_in   = |s_axi.AWADDR[S_AXI_ADDR_WIDTH-1:IW+2];
    assign ar_oor_in   = |s_axi.ARADDR[S_AXI_ADDR_WIDTH-1:IW+2];
    assign unused_addr = ^{s_axi.AWADDR[1:0], s_axi.ARADDR[1:0]};
`else
    // Upper address bits are don't-care: accesses alias modulo NUM_REG.
    assign aw_oor_in   = 1'b0;
    assign ar_oor_in   = 1'b0;
    assign unused_addr = ^{s_axi.AWADDR[S_AXI_ADDR_WIDTH-1:IW+2], s_axi.AWADDR[1:0],
                           s_axi.ARADDR[S_AXI_ADDR_WIDTH-1:IW+2], s_axi.ARADDR[1:0]};
`endif

    always_comb begin
        wr_state_d = wr_state_q;
        aw_idx_d   = aw_idx_q;
        aw_oor_d   = aw_oor_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        bresp_d    = bresp_q;
        commit     = 1'b0;
        cm_idx     = aw_idx_q;
        cm_oor     = aw_oor_q;
        cm_data    = wdata_q;
        cm_strb    = wstrb_q;
        case (wr_state_q)
            WR_IDLE: begin
                if (aw_hs && w_hs) begin
                    commit  = 1'b1;
                    cm_idx  = s_axi.AWADDR[IW+1:2];
                    cm_oor  = aw_oor_in;
                    cm_data = s_axi.WDATA;
                    cm_strb = s_axi.WSTRB;
                end else if (aw_hs) begin
                    aw_idx_d   = s_axi.AWADDR[IW+1:2];
                    aw_oor_d   = aw_oor_in;
                    wr_state_d = WR_HAVE_AW;
                end else if (w_hs) begin
                    wdata_d    = s_axi.WDATA;
                    wstrb_d    = s_axi.WSTRB;
                    wr_state_d = WR_HAVE_W;
                end
            end
            WR_HAVE_AW: begin
                if (w_hs) begin
                    commit  = 1'b1;
                    cm_data = s_axi.WDATA;
                    cm_strb = s_axi.WSTRB;
                end
            end
            WR_HAVE_W: begin
                if (aw_hs) begin
                    commit = 1'b1;
                    cm_idx = s_axi.AWADDR[IW+1:2];
                    cm_oor = aw_oor_in;
                end
            end
            WR_RESP: begin
                if (s_axi.BREADY) wr_state_d = WR_IDLE;
            end
        endcase
        if (commit) begin
            wr_state_d = WR_RESP;
            bresp_d    = cm_oor ? RESP_SLVERR : RESP_OKAY;
        end
    end

    // Readies come from the next state so they are registered yet never one cycle stale.
    assign rf_we     = commit && !cm_oor;
    assign awready_d = (wr_state_d == WR_IDLE) || (wr_state_d == WR_HAVE_W);
    assign wready_d  = (wr_state_d == WR_IDLE) || (wr_state_d == WR_HAVE_AW);
    assign bvalid_d  = (wr_state_d == WR_RESP);

    always_comb begin
        rd_state_d = rd_state_q;
        rdata_d    = rdata_q;
        rresp_d    = rresp_q;
        case (rd_state_q)
            RD_IDLE: begin
                if (ar_hs) begin
                    rd_state_d = RD_RESP;
                    rdata_d    = ar_oor_in ? '0 : rf_rdata;
                    rresp_d    = ar_oor_in ? RESP_SLVERR : RESP_OKAY;
                end
            end
            RD_RESP: begin
                if (s_axi.RREADY) rd_state_d = RD_IDLE;
            end
        endcase
    end

    assign arready_d = (rd_state_d == RD_IDLE);
    assign rvalid_d  = (rd_state_d == RD_RESP);

    always_ff @(posedge ACLK) begin
        if (!ARESET) begin
            wr_state_q <= WR_IDLE;
            rd_state_q <= RD_IDLE;
            aw_idx_q   <= '0;
            aw_oor_q   <= 1'b0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            bvalid_q   <= 1'b0;
            bresp_q    <= RESP_OKAY;
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            rresp_q    <= RESP_OKAY;
        end else begin
            wr_state_q <= wr_state_d;
            rd_state_q <= rd_state_d;
            aw_idx_q   <= aw_idx_d;
            aw_oor_q   <= aw_oor_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            awready_q  <= awready_d;
            wready_q   <= wready_d;
            bvalid_q   <= bvalid_d;
            bresp_q    <= bresp_d;
            arready_q  <= arready_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
        end
    end

    s_axil_register_file #(
        .NUM_REG    (NUM_REG),
        .DATA_WIDTH (DW)
    ) u_regs (
        .clk   (ACLK),
        .rst_n (ARESET),
        .we    (rf_we),
        .waddr (cm_idx),
        .wdata (cm_data),
        .wstrb (cm_strb),
        .raddr (s_axi.ARADDR[IW+1:2]),
        .rdata (rf_rdata)
    );

    assign s_axi.AWREADY = awready_q;
    assign s_axi.WREADY  = wready_q;
    assign s_axi.BVALID  = bvalid_q;
    assign s_axi.BRESP   = bresp_q;
    assign s_axi.ARREADY = arready_q;
    assign s_axi.RVALID  = rvalid_q;
    assign s_axi.RDATA   = rdata_q;
    assign s_axi.RRESP   = rresp_q;

endmodule

// File: tb/tb_s_axil_register.sv
// Bench for s_axil_register: directed and random AXI-Lite traffic checked every cycle against a transaction-level model.
module tb_s_axil_register;

    localparam int NUM_REG = 16;
`ifdef S_AXIL_REGISTER_SLVERR_EN
    localparam bit SLVERR = 1'b1;
`else
    localparam bit SLVERR = 1'b0;
`endif

    logic ACLK   = 1'b0;
    logic ARESET = 1'b0;
    always #5 ACLK = ~ACLK;

    s_axil_register_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();

    s_axil_register #(
        .S_AXI_DATA_WIDTH (32),
        .S_AXI_ADDR_WIDTH (32),
        .NUM_REG          (NUM_REG)
    ) dut (
        .ACLK   (ACLK),
        .ARESET (ARESET),
        .s_axi  (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string what);
        n_chk++;
        n_fail++;
        $display("FAIL timeout %s: actual no handshake required handshake (t=%0t)", what, $time);
    endtask

    function automatic bit oor(input logic [31:0] a);
        return SLVERR && (a >= 32'(NUM_REG * 4));
    endfunction

    // Transaction-level model: register array plus pending request/response bookkeeping.
    logic [31:0] m_reg [NUM_REG];
    bit          m_rdy     = 1'b0;
    bit          m_aw_have = 1'b0;
    logic [31:0] m_aw_addr = '0;
    bit          m_w_have  = 1'b0;
    logic [31:0] m_w_data  = '0;
    logic [3:0]  m_w_strb  = '0;
    bit          m_b_pend  = 1'b0;
    logic [1:0]  m_b_resp  = '0;
    bit          m_r_pend  = 1'b0;
    logic [31:0] m_r_data  = '0;
    logic [1:0]  m_r_resp  = '0;
    bit          mon_en    = 1'b0;

    always @(negedge ACLK) begin : monitor
        logic aw_hs, w_hs, ar_hs;
        logic [3:0] idx;
        if (mon_en) begin
            chk("AWREADY", 32'(bus.AWREADY), 32'(m_rdy && !m_b_pend && !m_aw_have));
            chk("WREADY",  32'(bus.WREADY),  32'(m_rdy && !m_b_pend && !m_w_have));
            chk("ARREADY", 32'(bus.ARREADY), 32'(m_rdy && !m_r_pend));
            chk("BVALID",  32'(bus.BVALID),  32'(m_b_pend));
            chk("RVALID",  32'(bus.RVALID),  32'(m_r_pend));
            if (m_b_pend || !m_rdy) chk("BRESP", 32'(bus.BRESP), m_b_pend ? 32'(m_b_resp) : 32'd0);
            if (m_r_pend || !m_rdy) begin
                chk("RDATA", bus.RDATA, m_r_pend ? m_r_data : 32'd0);
                chk("RRESP", 32'(bus.RRESP), m_r_pend ? 32'(m_r_resp) : 32'd0);
            end

            if (!ARESET) begin
                for (int i = 0; i < NUM_REG; i++) m_reg[i] = '0;
                m_rdy = 0; m_aw_have = 0; m_w_have = 0; m_b_pend = 0; m_r_pend = 0;
                m_b_resp = '0; m_r_data = '0; m_r_resp = '0;
            end else begin
                aw_hs = bus.AWVALID && bus.AWREADY;
                w_hs  = bus.WVALID  && bus.WREADY;
                ar_hs = bus.ARVALID && bus.ARREADY;
                if (m_b_pend && bus.BREADY) m_b_pend = 0;
                if (m_r_pend && bus.RREADY) m_r_pend = 0;
                // Read samples contents before any write landing on the same edge.
                if (ar_hs) begin
                    m_r_pend = 1;
                    m_r_resp = oor(bus.ARADDR) ? 2'b10 : 2'b00;
                    m_r_data = oor(bus.ARADDR) ? 32'd0 : m_reg[bus.ARADDR[5:2]];
                end
                if (aw_hs) begin m_aw_have = 1; m_aw_addr = bus.AWADDR; end
                if (w_hs)  begin m_w_have = 1; m_w_data = bus.WDATA; m_w_strb = bus.WSTRB; end
                if (m_aw_have && m_w_have) begin
                    idx = m_aw_addr[5:2];
                    if (oor(m_aw_addr)) m_b_resp = 2'b10;
                    else begin
                        m_b_resp = 2'b00;
                        for (int k = 0; k < 4; k++)
                            if (m_w_strb[k]) m_reg[idx][8*k +: 8] = m_w_data[8*k +: 8];
                    end
                    m_b_pend = 1; m_aw_have = 0; m_w_have = 0;
                end
                m_rdy = 1;
            end
        end
    end

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int awd, input int wd, input int bd, output logic [1:0] resp);
        bit aw_done = 0;
        bit w_done  = 0;
        int t = 0;
        resp = 2'bxx;
        bus.AWADDR = a; bus.WDATA = d; bus.WSTRB = s;
        while (!(aw_done && w_done)) begin
            bus.AWVALID = !aw_done && (t >= awd);
            bus.WVALID  = !w_done && (t >= wd);
            @(negedge ACLK);
            if (bus.AWVALID && bus.AWREADY) aw_done = 1;
            if (bus.WVALID && bus.WREADY) w_done = 1;
            @(posedge ACLK); #1;
            t++;
            if (t > 200) begin timeout("write address/data"); break; end
        end
        bus.AWVALID = 0; bus.WVALID = 0;
        t = 0;
        while (1) begin
            bus.BREADY = (t >= bd);
            @(negedge ACLK);
            if (bus.BVALID && bus.BREADY) begin resp = bus.BRESP; break; end
            @(posedge ACLK); #1;
            t++;
            if (t > 200) begin timeout("write response"); break; end
        end
        @(posedge ACLK); #1;
        bus.BREADY = 0;
    endtask

    task automatic do_read(input logic [31:0] a, input int rd,
                           output logic [31:0] data, output logic [1:0] resp);
        int t = 0;
        data = 'x; resp = 2'bxx;
        bus.ARADDR = a; bus.ARVALID = 1;
        while (1) begin
            @(negedge ACLK);
            if (bus.ARREADY) break;
            @(posedge ACLK); #1;
            t++;
            if (t > 200) begin timeout("read address"); bus.ARVALID = 0; return; end
        end
        @(posedge ACLK); #1;
        bus.ARVALID = 0;
        t = 0;
        while (1) begin
            bus.RREADY = (t >= rd);
            @(negedge ACLK);
            if (bus.RVALID && bus.RREADY) begin data = bus.RDATA; resp = bus.RRESP; break; end
            @(posedge ACLK); #1;
            t++;
            if (t > 200) begin timeout("read response"); break; end
        end
        @(posedge ACLK); #1;
        bus.RREADY = 0;
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: actual still running required finished");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        logic [1:0]  resp;
        logic [31:0] data;
        logic [1:0]  exp_resp;
        logic [31:0] exp_d40, exp_d0;

        bus.AWADDR = '0; bus.AWVALID = 0; bus.WDATA = '0; bus.WSTRB = '0; bus.WVALID = 0;
        bus.BREADY = 0; bus.ARADDR = '0; bus.ARVALID = 0; bus.RREADY = 0;
        repeat (3) @(posedge ACLK);
        #1 mon_en = 1;
        @(posedge ACLK); #1;
        ARESET = 1;
        @(posedge ACLK); #1;
        chk("ready after reset", {29'd0, bus.AWREADY, bus.WREADY, bus.ARREADY}, 32'd7);

        // Fill 1..16 then read back.
        for (int i = 0; i < 16; i++) begin
            do_write(32'(4 * i), 32'(i + 1), 4'hF, 0, 0, 0, resp);
            chk("fill bresp", 32'(resp), 32'd0);
        end
        for (int i = 0; i < 16; i++) begin
            do_read(32'(4 * i), 0, data, resp);
            chk("fill rdata", data, 32'(i + 1));
            chk("fill rresp", 32'(resp), 32'd0);
        end

        // W leads AW, then AW leads W.
        do_write(32'h08, 32'hA5A5A5A5, 4'hF, 2, 0, 0, resp);
        chk("w-first bresp", 32'(resp), 32'd0);
        do_write(32'h08, 32'hA5A5A5A5, 4'hF, 0, 2, 0, resp);
        chk("aw-first bresp", 32'(resp), 32'd0);
        do_read(32'h08, 0, data, resp);
        chk("split readback", data, 32'hA5A5A5A5);

        // Byte strobes and an empty strobe.
        do_write(32'h10, 32'hFFFFFFFF, 4'hF, 0, 0, 0, resp);
        do_write(32'h10, 32'h00000000, 4'b0101, 0, 0, 0, resp);
        do_read(32'h10, 0, data, resp);
        chk("strobe readback", data, 32'hFF00FF00);
        do_write(32'h13, 32'h12345678, 4'b0000, 0, 0, 0, resp);
        chk("zero strobe bresp", 32'(resp), 32'd0);
        do_read(32'h10, 0, data, resp);
        chk("zero strobe readback", data, 32'hFF00FF00);

        // Back-pressure on both response channels.
        do_write(32'h14, 32'hCAFEF00D, 4'hF, 0, 0, 5, resp);
        chk("stall bresp", 32'(resp), 32'd0);
        do_read(32'h14, 5, data, resp);
        chk("stall rdata", data, 32'hCAFEF00D);

        // Address just past the bank.
`ifdef S_AXIL_REGISTER_SLVERR_EN
        exp_resp = 2'b10; exp_d40 = 32'd0;         exp_d0 = 32'd1;
`else
        exp_resp = 2'b00; exp_d40 = 32'hDEADBEEF;  exp_d0 = 32'hDEADBEEF;
`endif
        do_write(32'h40, 32'hDEADBEEF, 4'hF, 0, 0, 0, resp);
        chk("0x40 bresp", 32'(resp), 32'(exp_resp));
        do_read(32'h40, 0, data, resp);
        chk("0x40 rdata", data, exp_d40);
        chk("0x40 rresp", 32'(resp), 32'(exp_resp));
        do_read(32'h00, 0, data, resp);
        chk("reg0 after 0x40", data, exp_d0);

        // Same-cycle read and write of one register returns the old value.
        fork
            do_write(32'h0C, 32'h12345678, 4'hF, 0, 0, 0, resp);
            do_read(32'h0C, 0, data, exp_resp);
        join
        chk("same-cycle rdata", data, 32'd4);
        do_read(32'h0C, 0, data, resp);
        chk("same-cycle after", data, 32'h12345678);

        // Reset while an address is held without data.
        bus.AWADDR = 32'h18; bus.AWVALID = 1;
        @(posedge ACLK); #1;
        bus.AWVALID = 0;
        ARESET = 0;
        @(posedge ACLK); #1;
        ARESET = 1;
        chk("reset valids", {30'd0, bus.BVALID, bus.RVALID}, 32'd0);
        chk("reset readies", {29'd0, bus.AWREADY, bus.WREADY, bus.ARREADY}, 32'd0);
        @(posedge ACLK); #1;
        do_read(32'h04, 0, data, resp);
        chk("reg1 after reset", data, 32'd0);
        do_read(32'h18, 0, data, resp);
        chk("reg6 after reset", data, 32'd0);
        do_write(32'h18, 32'h00000077, 4'hF, 0, 1, 0, resp);
        chk("post-reset bresp", 32'(resp), 32'd0);
        do_read(32'h18, 0, data, resp);
        chk("post-reset readback", data, 32'h00000077);

        // Random concurrent traffic; the monitor checks every response.
        fork
            begin
                logic [1:0] r;
                for (int n = 0; n < 60; n++) begin
                    do_write(32'($urandom_range(0, 31) * 4 + $urandom_range(0, 3)), $urandom,
                             4'($urandom_range(0, 15)), $urandom_range(0, 3), $urandom_range(0, 3),
                             $urandom_range(0, 3), r);
                end
            end
            begin
                logic [31:0] d;
                logic [1:0]  r;
                for (int n = 0; n < 60; n++) begin
                    repeat ($urandom_range(0, 2)) begin @(posedge ACLK); #1; end
                    do_read(32'($urandom_range(0, 31) * 4 + $urandom_range(0, 3)),
                            $urandom_range(0, 3), d, r);
                end
            end
        join

        repeat (3) @(posedge ACLK);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
